comp_1bit: RTL and testbench

Registered 1-bit magnitude comparator with cascade inputs, a valid handshake and saturating outcome counters. It compares one bit of A against one bit of B and produces exactly one of greater, equal or less. It is the bit-slice primitive for building wider comparators: slices are chained by feeding a lower-significance slice's result into the cascade inputs. The counters give the verification and debug logic outcome statistics.

---
 rtl/comp_1bit.sv | 158 +++++++++++++++
 tb/tb_comp_1bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/comp_1bit.sv
// -----------------------------------------------------------------------------
// comp_1bit
//   Registered 1-bit magnitude comparator slice with cascade inputs, a valid
//   handshake and saturating per-outcome counters. Chain slices by feeding a
//   lower-significance slice's G0/E0/L0 into gt_in/eq_in/lt_in of the next
//   more-significant slice. For standalone use tie gt_in=0, eq_in=1, lt_in=0.
//
// Parameters
//   CNT_W     width of each outcome counter (1..32)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   A0, B0    operand bits
//   in_valid  operands and cascade inputs are sampled this cycle
//   gt_in     cascade "greater" from the lower-significance slice
//   eq_in     cascade "equal" (implied by ~gt_in & ~lt_in; accepted for
//             symmetric chaining only)
//   lt_in     cascade "less" from the lower-significance slice
//   cnt_clr   synchronous clear of all three counters
//   G0/E0/L0  registered result: A>B / A==B / A<B (one-hot once loaded)
//   out_valid G0/E0/L0 were loaded on the previous edge
//   cnt_gt/cnt_eq/cnt_lt  saturating counts of accepted samples per outcome
// -----------------------------------------------------------------------------
module comp_1bit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A0,
  input  logic             B0,
  input  logic             in_valid,
  input  logic             gt_in,
  input  logic             eq_in,
  input  logic             lt_in,
  input  logic             cnt_clr,
  output logic             E0,
  output logic             G0,
  output logic             L0,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_lt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The equal cascade input is fully determined by gt_in/lt_in: equality is
  // whatever is neither greater nor less, which also resolves illegal
  // non-one-hot cascade combinations deterministically.
  logic unused_eq_in;
  assign unused_eq_in = eq_in;

  // ---------------------------------------------------------------------------
  // Combinational compare
  // ---------------------------------------------------------------------------
  logic g_d, e_d, l_d;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    g_d = 1'b0;
    l_d = 1'b0;
    if (A0 && !B0) begin
      g_d = 1'b1;
    end else if (!A0 && B0) begin
      l_d = 1'b1;
    end else begin
      // Local bits tie: defer to the lower-significance result, gt first.
      g_d = gt_in;
      l_d = lt_in & ~gt_in;
    end
    e_d = ~g_d & ~l_d;
  end

  // ---------------------------------------------------------------------------
  // Result and valid registers
  // ---------------------------------------------------------------------------
  logic g_q, e_q, l_q, valid_q;
  logic g_nx, e_nx, l_nx;

  always_comb begin
    g_nx = g_q;
    e_nx = e_q;
    l_nx = l_q;
    if (in_valid) begin
      g_nx = g_d;
      e_nx = e_d;
      l_nx = l_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs as they were before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      l_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      g_q     <= g_nx;
      e_q     <= e_nx;
      l_q     <= l_nx;
      valid_q <= in_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating outcome counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_gt_q, cnt_eq_q, cnt_lt_q;
  logic [CNT_W-1:0] cnt_gt_d, cnt_eq_d, cnt_lt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    cnt_gt_d = cnt_gt_q;
    cnt_eq_d = cnt_eq_q;
    cnt_lt_d = cnt_lt_q;
    if (cnt_clr) begin
      // Clear wins over a same-cycle increment.
      cnt_gt_d = '0;
      cnt_eq_d = '0;
      cnt_lt_d = '0;
    end else if (in_valid) begin
      if (g_d) cnt_gt_d = sat_inc(cnt_gt_q);
      if (e_d) cnt_eq_d = sat_inc(cnt_eq_q);
      if (l_d) cnt_lt_d = sat_inc(cnt_lt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_gt_q <= '0;
      cnt_eq_q <= '0;
      cnt_lt_q <= '0;
    end else begin
      cnt_gt_q <= cnt_gt_d;
      cnt_eq_q <= cnt_eq_d;
      cnt_lt_q <= cnt_lt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all driven straight from registers
  // ---------------------------------------------------------------------------
  assign G0        = g_q;
  assign E0        = e_q;
  assign L0        = l_q;
  assign out_valid = valid_q;
  assign cnt_gt    = cnt_gt_q;
  assign cnt_eq    = cnt_eq_q;
  assign cnt_lt    = cnt_lt_q;

endmodule

// File: tb/tb_comp_1bit.sv
// -----------------------------------------------------------------------------
// tb_comp_1bit
//   Self-checking bench for comp_1bit (CNT_W=2 so saturation is reachable).
//   Stimulus pushes the hand-computed result plus the expected counter values
//   into a scoreboard queue; a monitor pops and compares on every cycle the
//   DUT presents out_valid. Idle-hold and reset behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_comp_1bit;

  localparam int unsigned CW   = 2;
  localparam int unsigned CMAX = (1 << CW) - 1;

  localparam logic [2:0] R_G = 3'b100;  // {G,E,L}
  localparam logic [2:0] R_E = 3'b010;
  localparam logic [2:0] R_L = 3'b001;

  logic          clk = 1'b0;
  logic          rst;
  logic          A0, B0, in_valid, gt_in, eq_in, lt_in, cnt_clr;
  logic          E0, G0, L0, out_valid;
  logic [CW-1:0] cnt_gt, cnt_eq, cnt_lt;

  comp_1bit #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .A0        (A0),
    .B0        (B0),
    .in_valid  (in_valid),
    .gt_in     (gt_in),
    .eq_in     (eq_in),
    .lt_in     (lt_in),
    .cnt_clr   (cnt_clr),
    .E0        (E0),
    .G0        (G0),
    .L0        (L0),
    .out_valid (out_valid),
    .cnt_gt    (cnt_gt),
    .cnt_eq    (cnt_eq),
    .cnt_lt    (cnt_lt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    gel;
    logic [CW-1:0] cg;
    logic [CW-1:0] ce;
    logic [CW-1:0] cl;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned m_gt, m_eq, m_lt;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive one accepted sample; exp_gel is the hand-computed result. The
  // counter model follows the hand result with saturation and clear.
  task automatic send(input logic a, input logic b, input logic gt,
                      input logic eq, input logic lt, input logic clr,
                      input logic [2:0] exp_gel);
    exp_t e;
    @(posedge clk); #1;
    A0 = a; B0 = b; gt_in = gt; eq_in = eq; lt_in = lt;
    cnt_clr = clr; in_valid = 1'b1;
    if (clr) begin
      m_gt = 0; m_eq = 0; m_lt = 0;
    end else begin
      if (exp_gel == R_G && m_gt < CMAX) m_gt++;
      if (exp_gel == R_E && m_eq < CMAX) m_eq++;
      if (exp_gel == R_L && m_lt < CMAX) m_lt++;
    end
    e.gel = exp_gel;
    e.cg  = CW'(m_gt);
    e.ce  = CW'(m_eq);
    e.cl  = CW'(m_lt);
    sb_q.push_back(e);
  endtask

  task automatic idle_edge();
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  // Let the last sample get sampled and reach the monitor.
  task automatic drain();
    idle_edge();
    @(negedge clk); #1;
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_gel_counters",
              32'({G0, E0, L0, cnt_gt, cnt_eq, cnt_lt}), 32'(mon_e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; A0 = 0; B0 = 0; in_valid = 0;
    gt_in = 0; eq_in = 1; lt_in = 0; cnt_clr = 0;
    m_gt = 0; m_eq = 0; m_lt = 0;

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("reset_state", 32'({G0, E0, L0, out_valid, cnt_gt, cnt_eq, cnt_lt}),
          32'd0);

    // Standalone comparator on consecutive cycles.
    send(0, 0, 0, 1, 0, 0, R_E);
    send(0, 1, 0, 1, 0, 0, R_L);
    send(1, 0, 0, 1, 0, 0, R_G);
    send(1, 1, 0, 1, 0, 0, R_E);
    drain();
    check("cnt_after_standalone", 32'({cnt_gt, cnt_eq, cnt_lt}),
          32'({CW'(1), CW'(2), CW'(1)}));

    // Cascade pass-through and local-bit dominance.
    send(1, 1, 1, 0, 0, 0, R_G);
    send(1, 1, 0, 0, 1, 0, R_L);
    send(1, 1, 1, 0, 1, 0, R_G);
    send(1, 1, 0, 0, 0, 0, R_E);
    send(1, 0, 0, 0, 1, 0, R_G);
    drain();

    // Hold behaviour once in_valid drops after a G sample.
    send(1, 0, 0, 1, 0, 0, R_G);
    idle_edge();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_g0_held", 32'(G0), 32'd1);
      check("idle_cnt_gt_held", 32'(cnt_gt), 32'(CMAX));
    end

    // Asynchronous reset between edges with a result on the outputs.
    send(0, 1, 0, 1, 0, 0, R_L);
    @(posedge clk); #2;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; in_valid = 1'b0;
    sb_q.delete();
    m_gt = 0; m_eq = 0; m_lt = 0;
    #1;
    check("async_reset_clear",
          32'({G0, E0, L0, out_valid, cnt_gt, cnt_eq, cnt_lt}), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Saturation of cnt_eq, then clear together with a valid sample.
    for (int i = 0; i < 5; i++) send(0, 0, 0, 1, 0, 0, R_E);
    drain();
    check("cnt_eq_saturated", 32'(cnt_eq), 32'd3);
    send(1, 1, 0, 1, 0, 1, R_E);
    send(0, 1, 0, 1, 0, 0, R_L);
    drain();
    check("cnt_after_clear", 32'({cnt_gt, cnt_eq, cnt_lt}),
          32'({CW'(0), CW'(0), CW'(1)}));

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
